lc3b_mem_responder: RTL
=======================

Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b CPU's memory interface (mem_read / mem_write / mem_wmask / mem_address / mem_wdata / mem_rdata / mem_resp).
- Answers each CPU request after a fixed, parameterised latency from an internal word array with byte-lane write enables.
- Used as the memory model under the datapath/control pair in simulation, and as on-chip RAM in synthesis.

Parameters:
- ADDR_BITS, 8: word-index width; array depth is 2**ADDR_BITS 16-bit words.
- LATENCY, 3: cycles from request acceptance to the mem_resp pulse; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  read request, level.
- mem_write  in  1  write request, level.
- mem_wmask  in  2  lc3b_mem_wmask; [0] enables the low byte, [1] enables the high byte.
- mem_address  in  16  lc3b_word byte address; bit 0 ignored.
- mem_wdata  in  16  lc3b_word write data.
- mem_rdata  out  16  lc3b_word read data; valid while mem_resp=1.
- mem_resp  out  1  single-cycle completion pulse.

Behaviour:
- Reset is asynchronous: state=IDLE, mem_resp=0, mem_rdata=16'h0000, latency counter=0, latched request cleared. Array contents are not reset.
- Word index = mem_address[ADDR_BITS:1]. Address bits above that are ignored, so the array aliases/wraps.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If mem_read or mem_write is 1 at a clock edge, latch address, wdata, wmask and op.
  - Load counter with LATENCY-1 and go to BUSY. If LATENCY=1, go straight to RESP.
- BUSY:
  - Decrement the counter each cycle; go to RESP when it reaches 0.
  - Input changes during BUSY are ignored; only latched values are used.
- RESP (exactly one cycle, mem_resp=1):
  - Read: mem_rdata = array[latched index], registered on entry to RESP.
  - Write: the array updates at the RESP-entry edge on enabled byte lanes only. mem_rdata shows the post-write word.
  - Always returns to IDLE.
- Total latency: request sampled at edge N, mem_resp high during cycle N+LATENCY.
- After RESP, IDLE re-samples at the next edge. A request held high after mem_resp is treated as a new request; the CPU drops its request in the cycle after mem_resp.
- Both mem_read and mem_write asserted: treated as a write. mem_rdata returns the post-write word.
- wmask=2'b00 on a write: no array change, mem_resp still pulses.
- Request deasserted mid-BUSY: the transaction still completes and pulses mem_resp.
- reset_n low mid-transaction: the transaction is aborted and no array update occurs unless the RESP-entry edge already happened.
- mem_rdata holds its last value outside RESP.

Optional Feature:
- Macro: LC3B_MEM_ERR_EN.
- When defined:
  - Adds output mem_err (1 bit, reset 0).
  - mem_err pulses together with mem_resp when the latched request had read and write both set, or was a write with wmask=2'b00.
- When undefined: no mem_err port, and no extra logic is generated.

Decomposition:
- Package lc3b_types already supplies lc3b_word and lc3b_mem_wmask.
- Add to lc3b_types: enum lc3b_memresp_state {mr_idle, mr_busy, mr_resp} and a 4-bit typedef lc3b_lat_count.
- Sub-module lc3b_mem_array:
  - 2**ADDR_BITS x 16 storage with a byte-enable synchronous write and a combinational read port.
  - The FSM and counter stay in lc3b_mem_responder.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, then release -> mem_resp=0, mem_rdata=16'h0000, no response for 5 cycles with requests idle.
- Full write then read (LATENCY=3): write 16'hBEEF to address 16'h0010 with wmask=2'b11 -> mem_resp in cycle N+3. Then read 16'h0010 -> mem_rdata=16'hBEEF with mem_resp exactly 3 cycles after acceptance, pulse width 1.
- Byte lanes: after the above, write 16'h1234 to 16'h0010 with wmask=2'b01, then read -> 16'hBE34. Write 16'h5600 with wmask=2'b10, then read -> 16'h5634.
- Aliasing: with ADDR_BITS=8, write 16'hA5A5 to 16'h0202 -> read of 16'h0002 returns 16'hA5A5. Read of 16'h0003 (odd byte address) also returns 16'hA5A5.
- Mid-BUSY input change: read 16'h0010, then change mem_address to 16'h0020 and drop mem_read one cycle later -> mem_resp still fires with the data at 16'h0010. Async reset asserted during BUSY -> mem_resp never pulses.
- LATENCY=1 plus error feature (LC3B_MEM_ERR_EN defined): assert read and write together with wdata=16'h0F0F, wmask=2'b11 -> mem_resp and mem_err both high one cycle after acceptance, and mem_rdata=16'h0F0F.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b type definitions used by the memory responder.
// Provides the word and write-mask types, the responder FSM state, the
// latency counter type and the latched request payload.
// Optional feature macro: LC3B_MEM_ERR_EN adds the request "both ops" flag.
package lc3b_types;

  localparam int unsigned WORD_BITS = 16;
  localparam int unsigned LAT_BITS  = 4;

  typedef logic [WORD_BITS-1:0] lc3b_word;
  typedef logic [1:0]           lc3b_mem_wmask;
  typedef logic [LAT_BITS-1:0]  lc3b_lat_count;

  typedef enum logic [1:0] {
    mr_idle,
    mr_busy,
    mr_resp
  } lc3b_memresp_state;

  // Request captured at acceptance; only these values drive the transaction.
  typedef struct packed {
    logic          wr;
`ifdef LC3B_MEM_ERR_EN
    logic          both;
`endif
    lc3b_mem_wmask wmask;
    lc3b_word      addr;
    lc3b_word      wdata;
  } lc3b_mem_req_t;

  // Byte-lane merge of new data into an old word.
  function automatic lc3b_word merge_bytes(input lc3b_word old_w,
                                           input lc3b_word new_w,
                                           input lc3b_mem_wmask m);
    lc3b_word lane;
    lane = {{8{m[1]}}, {8{m[0]}}};
    return (old_w & ~lane) | (new_w & lane);
  endfunction

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// lc3b_mem_responder_if: LC-3b CPU <-> memory bus.
//   master (CPU):    drives mem_read, mem_write, mem_wmask, mem_address, mem_wdata
//   slave  (memory): drives mem_rdata, mem_resp (and mem_err with LC3B_MEM_ERR_EN)
interface lc3b_mem_responder_if;
  import lc3b_types::*;

  logic          mem_read;
  logic          mem_write;
  lc3b_mem_wmask mem_wmask;
  lc3b_word      mem_address;
  lc3b_word      mem_wdata;
  lc3b_word      mem_rdata;
  logic          mem_resp;
`ifdef LC3B_MEM_ERR_EN
  logic          mem_err;
`endif

  modport master (
    output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
`ifdef LC3B_MEM_ERR_EN
    input  mem_err,
`endif
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
`ifdef LC3B_MEM_ERR_EN
    output mem_err,
`endif
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/lc3b_mem_array.sv
// lc3b_mem_array: 2**ADDR_BITS x 16 word storage.
//   clk       rising-edge clock
//   i_we      write enable
//   i_be      byte enables ([0] low byte, [1] high byte)
//   i_addr    word index (shared by read and write)
//   i_wdata   write data
//   o_rdata_c combinational read data at i_addr
// Contents are intentionally not reset.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  lc3b_mem_wmask        i_be,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  lc3b_word             i_wdata,
  output lc3b_word             o_rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  lc3b_word r_mem [DEPTH];

  // Byte-lane synchronous write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_be[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
      if (i_be[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
    end
  end

  assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: fixed-latency memory responder for the LC-3b CPU.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   mem      slave side of lc3b_mem_responder_if (request in, rdata/resp out)
// Parameters: ADDR_BITS (word-index width), LATENCY (1..15 cycles).
// A request sampled at edge N enters RESP at edge N+LATENCY-1; mem_resp is a
// one-cycle pulse. Writes land on the RESP-entry edge, byte lanes only.
// Optional feature macro: LC3B_MEM_ERR_EN adds mem_err (read+write together,
// or write with empty mask), pulsed alongside mem_resp.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 3
) (
  input logic                 clk,
  input logic                 reset_n,
  lc3b_mem_responder_if.slave mem
);

  localparam lc3b_lat_count LAT_LOAD = lc3b_lat_count'(LATENCY - 1);
  localparam bit            LAT_ONE  = (LATENCY == 1);

  lc3b_memresp_state r_state;
  lc3b_memresp_state w_next_state;

  lc3b_lat_count r_count;
  lc3b_lat_count w_count_d;
  lc3b_mem_req_t r_req;
  lc3b_mem_req_t w_req_d;
  lc3b_mem_req_t w_live_req;
  lc3b_mem_req_t w_cur_req;
  lc3b_word      r_rdata;
  lc3b_word      w_rdata_d;
  logic          r_resp;
  logic          w_resp_d;
  logic          w_we;
  logic          w_req_valid;
  lc3b_word      w_arr_rdata;
  lc3b_word      w_merged;
  logic [ADDR_BITS-1:0] w_idx;
  logic          w_unused_addr;
`ifdef LC3B_MEM_ERR_EN
  logic          r_err;
  logic          w_err_d;
`endif

  assign w_req_valid = mem.mem_read | mem.mem_write;

  // Incoming request as it would be latched; read+write is handled as a write.
  always_comb begin
    w_live_req       = '0;
    w_live_req.wr    = mem.mem_write;
`ifdef LC3B_MEM_ERR_EN
    w_live_req.both  = mem.mem_read & mem.mem_write;
`endif
    w_live_req.wmask = mem.mem_wmask;
    w_live_req.addr  = mem.mem_address;
    w_live_req.wdata = mem.mem_wdata;
  end

  // With LATENCY=1 RESP is entered from IDLE, so the live request is used.
  assign w_cur_req = (r_state == mr_idle) ? w_live_req : r_req;
  assign w_idx     = w_cur_req.addr[ADDR_BITS:1];
  assign w_merged  = merge_bytes(w_arr_rdata, w_cur_req.wdata, w_cur_req.wmask);

  // Byte address bit 0 and bits above the index alias away.
  assign w_unused_addr = ^{w_cur_req.addr[WORD_BITS-1:ADDR_BITS+1], w_cur_req.addr[0]};

  lc3b_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk       (clk),
    .i_we      (w_we),
    .i_be      (w_cur_req.wmask),
    .i_addr    (w_idx),
    .i_wdata   (w_cur_req.wdata),
    .o_rdata_c (w_arr_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= mr_idle;
    else          r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      mr_idle: if (w_req_valid) w_next_state = LAT_ONE ? mr_resp : mr_busy;
      mr_busy: if (r_count <= lc3b_lat_count'(1)) w_next_state = mr_resp;
      mr_resp: w_next_state = mr_idle;
      default: w_next_state = mr_idle;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_count_d = r_count;
    w_req_d   = r_req;
    w_rdata_d = r_rdata;
    w_resp_d  = 1'b0;
    w_we      = 1'b0;
`ifdef LC3B_MEM_ERR_EN
    w_err_d   = 1'b0;
`endif
    case (r_state)
      mr_idle: begin
        if (w_req_valid) begin
          w_count_d = LAT_LOAD;
          w_req_d   = w_live_req;
        end
      end
      mr_busy: w_count_d = r_count - lc3b_lat_count'(1);
      default: ;
    endcase
    if (w_next_state == mr_resp) begin
      w_resp_d  = 1'b1;
      // reset_n gate keeps a held request from writing while in reset.
      w_we      = w_cur_req.wr & reset_n;
      w_rdata_d = w_cur_req.wr ? w_merged : w_arr_rdata;
`ifdef LC3B_MEM_ERR_EN
      w_err_d   = w_cur_req.both | (w_cur_req.wr & (w_cur_req.wmask == 2'b00));
`endif
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_req   <= '0;
      r_rdata <= '0;
      r_resp  <= 1'b0;
`ifdef LC3B_MEM_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_count <= w_count_d;
      r_req   <= w_req_d;
      r_rdata <= w_rdata_d;
      r_resp  <= w_resp_d;
`ifdef LC3B_MEM_ERR_EN
      r_err   <= w_err_d;
`endif
    end
  end

  assign mem.mem_rdata = r_rdata;
  assign mem.mem_resp  = r_resp;
`ifdef LC3B_MEM_ERR_EN
  assign mem.mem_err   = r_err;
`endif

endmodule
